// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302 responder: register addresses, command-byte
// fields, register reset values and the BCD calendar helpers.
package ds1302_pkg;

    localparam int CMD_RD_BIT    = 0;
    localparam int CMD_RAM_BIT   = 6;
    localparam int CMD_VALID_BIT = 7;

    localparam logic [4:0] ADDR_SEC      = 5'd0;
    localparam logic [4:0] ADDR_MIN      = 5'd1;
    localparam logic [4:0] ADDR_HOUR     = 5'd2;
    localparam logic [4:0] ADDR_DATE     = 5'd3;
    localparam logic [4:0] ADDR_MONTH    = 5'd4;
    localparam logic [4:0] ADDR_DAY      = 5'd5;
    localparam logic [4:0] ADDR_YEAR     = 5'd6;
    localparam logic [4:0] ADDR_WP       = 5'd7;
    localparam logic [4:0] ADDR_TCS      = 5'd8;
    localparam logic [4:0] ADDR_BURST    = 5'd31;
    localparam logic [4:0] ADDR_CK_LAST  = 5'd7;
    localparam logic [4:0] ADDR_RAM_LAST = 5'd30;

    localparam logic [7:0] RST_SEC   = 8'h80;
    localparam logic [7:0] RST_MIN   = 8'h00;
    localparam logic [7:0] RST_HOUR  = 8'h00;
    localparam logic [7:0] RST_DATE  = 8'h01;
    localparam logic [7:0] RST_MONTH = 8'h01;
    localparam logic [7:0] RST_DAY   = 8'h01;
    localparam logic [7:0] RST_YEAR  = 8'h00;
    localparam logic [7:0] RST_WP    = 8'h00;
    localparam logic [7:0] RST_TCS   = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_SKIP
    } state_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    // Returns the last BCD date of the month; leap test works on the binary value of the BCD year.
    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [7:0] year);
        logic [7:0] year_bin;
        logic [7:0] r;
        year_bin = ({4'd0, year[7:4]} * 8'd10) + {4'd0, year[3:0]};
        case (month)
            8'h02:                      r = ((year_bin % 8'd4) == 8'd0) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
            default:                    r = 8'h31;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ds1302_timekeeper.sv
// Prescaler and BCD time/calendar chain of the DS1302 responder, with a load
// port through which serial writes overwrite individual time registers.
module ds1302_timekeeper
    import ds1302_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_en,
    input  logic [4:0] load_addr,
    input  logic [7:0] load_data,
    output logic       tick,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic [7:0] date,
    output logic [7:0] month,
    output logic [7:0] day,
    output logic [7:0] year
);

    localparam int PW = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [7:0] date_q, date_d, month_q, month_d, day_q, day_d, year_q, year_d;
    logic       carry;

    assign tick  = (presc_q == PRESC_MAX);
    assign sec   = sec_q;
    assign min   = min_q;
    assign hour  = hour_q;
    assign date  = date_q;
    assign month = month_q;
    assign day   = day_q;
    assign year  = year_q;

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        date_d  = date_q;
        month_d = month_q;
        day_d   = day_q;
        year_d  = year_q;
        carry   = tick && !sec_q[7];

        if (carry) begin
            if (sec_q >= 8'h59) begin
                sec_d = 8'h00;
            end else begin
                sec_d = bcd_inc(sec_q);
                carry = 1'b0;
            end
        end
        if (carry) begin
            if (min_q >= 8'h59) begin
                min_d = 8'h00;
            end else begin
                min_d = bcd_inc(min_q);
                carry = 1'b0;
            end
        end
        if (carry) begin
            if (hour_q >= 8'h23) begin
                hour_d = 8'h00;
            end else begin
                hour_d = bcd_inc(hour_q);
                carry  = 1'b0;
            end
        end
        if (carry) begin
            day_d = (day_q >= 8'h07) ? 8'h01 : bcd_inc(day_q);
            if (date_q >= days_in_month(month_q, year_q)) begin
                date_d = 8'h01;
            end else begin
                date_d = bcd_inc(date_q);
                carry  = 1'b0;
            end
        end
        if (carry) begin
            if (month_q >= 8'h12) begin
                month_d = 8'h01;
            end else begin
                month_d = bcd_inc(month_q);
                carry   = 1'b0;
            end
        end
        if (carry) begin
            year_d = (year_q >= 8'h99) ? 8'h00 : bcd_inc(year_q);
        end

        // A load replaces whatever the tick computed for that register.
        if (load_en) begin
            case (load_addr)
                ADDR_SEC: begin
                    sec_d   = load_data;
                    presc_d = '0;
                end
                ADDR_MIN:   min_d   = load_data;
                ADDR_HOUR:  hour_d  = {1'b0, load_data[6:0]};
                ADDR_DATE:  date_d  = load_data;
                ADDR_MONTH: month_d = load_data;
                ADDR_DAY:   day_d   = load_data;
                ADDR_YEAR:  year_d  = load_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            sec_q   <= RST_SEC;
            min_q   <= RST_MIN;
            hour_q  <= RST_HOUR;
            date_q  <= RST_DATE;
            month_q <= RST_MONTH;
            day_q   <= RST_DAY;
            year_q  <= RST_YEAR;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            date_q  <= date_d;
            month_q <= month_d;
            day_q   <= day_d;
            year_q  <= year_d;
        end
    end

endmodule

// File: rtl/ds1302_responder.sv
// DS1302 3-wire RTC responder: serial command decode, single/burst access, read
// shadow and WP/TCS registers. Define DS1302_RAM_EN to add the 31-byte user RAM.
module ds1302_responder
    import ds1302_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ds1302_ce,
    input  logic ds1302_sclk,
    input  logic ds1302_io_i,
    output logic ds1302_io_o,
    output logic ds1302_io_oe,
    output logic tick_1hz,
    output logic halted
);

    logic [1:0] ce_sync_q, ce_sync_d, sclk_sync_q, sclk_sync_d, io_sync_q, io_sync_d;
    logic       ce_prev_q, ce_prev_d, sclk_prev_q, sclk_prev_d;
    logic       ce_s, sclk_s, io_s, ce_rise, sclk_rise, sclk_fall;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, rd_shift_q, rd_shift_d;
    logic [4:0] addr_q, addr_d, next_addr;
    logic       ram_sel_q, ram_sel_d, burst_q, burst_d;
    logic       io_o_q, io_o_d, io_oe_q, io_oe_d;
    logic [7:0] wp_q, wp_d, tcs_q, tcs_d;
    logic [7:0] shadow_q [7];
    logic [7:0] shadow_d [7];
    logic [7:0] in_byte, rd_val;
    logic       commit_en, tk_load;

    logic [7:0] tk_sec, tk_min, tk_hour, tk_date, tk_month, tk_day, tk_year;

    ds1302_timekeeper #(.CLK_FREQ(CLK_FREQ)) u_timekeeper (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (tk_load),
        .load_addr (addr_q),
        .load_data (in_byte),
        .tick      (tick_1hz),
        .sec       (tk_sec),
        .min       (tk_min),
        .hour      (tk_hour),
        .date      (tk_date),
        .month     (tk_month),
        .day       (tk_day),
        .year      (tk_year)
    );

    assign halted       = tk_sec[7];
    assign ds1302_io_o  = io_o_q;
    assign ds1302_io_oe = io_oe_q;

    assign ce_s      = ce_sync_q[1];
    assign sclk_s    = sclk_sync_q[1];
    assign io_s      = io_sync_q[1];
    assign ce_rise   = ce_s && !ce_prev_q;
    assign sclk_rise = sclk_s && !sclk_prev_q;
    assign sclk_fall = !sclk_s && sclk_prev_q;
    assign in_byte   = {io_s, shift_q[7:1]};

    always_comb begin
        ce_sync_d   = {ce_sync_q[0], ds1302_ce};
        sclk_sync_d = {sclk_sync_q[0], ds1302_sclk};
        io_sync_d   = {io_sync_q[0], ds1302_io_i};
        ce_prev_d   = ce_s;
        sclk_prev_d = sclk_s;
    end

`ifdef DS1302_RAM_EN
    logic [7:0] ram_q [0:30];
    logic [7:0] ram_d [0:30];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 31; i++) begin
                ram_q[i] <= 8'h00;
            end
        end else begin
            ram_q <= ram_d;
        end
    end
`endif

    // Burst address sequence: clock burst cycles 0..7, RAM burst cycles 0..30.
    always_comb begin
        if (ram_sel_q) begin
            next_addr = (addr_q >= ADDR_RAM_LAST) ? 5'd0 : addr_q + 5'd1;
        end else begin
            next_addr = (addr_q >= ADDR_CK_LAST) ? 5'd0 : addr_q + 5'd1;
        end
    end

    always_comb begin
        rd_val = 8'h00;
        if (ram_sel_q) begin
`ifdef DS1302_RAM_EN
            if (addr_q <= ADDR_RAM_LAST) begin
                rd_val = ram_q[addr_q];
            end
`else
            rd_val = 8'h00;
`endif
        end else if (addr_q <= ADDR_YEAR) begin
            rd_val = shadow_q[addr_q[2:0]];
        end else if (addr_q == ADDR_WP) begin
            rd_val = wp_q;
        end else if (addr_q == ADDR_TCS) begin
            rd_val = tcs_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rd_shift_d = rd_shift_q;
        addr_d     = addr_q;
        ram_sel_d  = ram_sel_q;
        burst_d    = burst_q;
        io_o_d     = io_o_q;
        io_oe_d    = io_oe_q;
        shadow_d   = shadow_q;
        commit_en  = 1'b0;

        if (!ce_s) begin
            state_d   = ST_IDLE;
            io_oe_d   = 1'b0;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ce_rise) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shift_d   = in_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            shadow_d  = '{tk_sec, tk_min, tk_hour, tk_date, tk_month, tk_day, tk_year};
                            ram_sel_d = in_byte[CMD_RAM_BIT];
                            burst_d   = (in_byte[5:1] == ADDR_BURST);
                            addr_d    = (in_byte[5:1] == ADDR_BURST) ? 5'd0 : in_byte[5:1];
                            if (!in_byte[CMD_VALID_BIT]) begin
                                state_d = ST_SKIP;
                            end else if (in_byte[CMD_RD_BIT]) begin
                                state_d = ST_RDATA;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        shift_d   = in_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            commit_en = 1'b1;
                            if (burst_q) begin
                                addr_d = next_addr;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (sclk_fall) begin
                        io_oe_d   = 1'b1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            io_o_d     = rd_val[0];
                            rd_shift_d = {1'b0, rd_val[7:1]};
                        end else begin
                            io_o_d     = rd_shift_q[0];
                            rd_shift_d = {1'b0, rd_shift_q[7:1]};
                        end
                        if (bit_cnt_q == 3'd7 && burst_q) begin
                            addr_d = next_addr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // WP shields every register but itself; TCS is storage only.
    always_comb begin
        wp_d    = wp_q;
        tcs_d   = tcs_q;
        tk_load = 1'b0;
`ifdef DS1302_RAM_EN
        ram_d   = ram_q;
`endif
        if (commit_en) begin
            if (!ram_sel_q) begin
                if (addr_q == ADDR_WP) begin
                    wp_d = {in_byte[7], 7'd0};
                end else if (!wp_q[7]) begin
                    if (addr_q <= ADDR_YEAR) begin
                        tk_load = 1'b1;
                    end else if (addr_q == ADDR_TCS) begin
                        tcs_d = in_byte;
                    end
                end
            end
`ifdef DS1302_RAM_EN
            else if (!wp_q[7] && addr_q <= ADDR_RAM_LAST) begin
                ram_d[addr_q] = in_byte;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_sync_q   <= 2'b00;
            sclk_sync_q <= 2'b00;
            io_sync_q   <= 2'b00;
            ce_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            rd_shift_q  <= 8'h00;
            addr_q      <= 5'd0;
            ram_sel_q   <= 1'b0;
            burst_q     <= 1'b0;
            io_o_q      <= 1'b0;
            io_oe_q     <= 1'b0;
            wp_q        <= RST_WP;
            tcs_q       <= RST_TCS;
            shadow_q    <= '{RST_SEC, RST_MIN, RST_HOUR, RST_DATE, RST_MONTH, RST_DAY, RST_YEAR};
        end else begin
            ce_sync_q   <= ce_sync_d;
            sclk_sync_q <= sclk_sync_d;
            io_sync_q   <= io_sync_d;
            ce_prev_q   <= ce_prev_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rd_shift_q  <= rd_shift_d;
            addr_q      <= addr_d;
            ram_sel_q   <= ram_sel_d;
            burst_q     <= burst_d;
            io_o_q      <= io_o_d;
            io_oe_q     <= io_oe_d;
            wp_q        <= wp_d;
            tcs_q       <= tcs_d;
            shadow_q    <= shadow_d;
        end
    end

endmodule
